// File: rtl/vedic_pp_combiner.sv
// vedic_pp_combiner: folds four (W/2)x(W/2) partial products into a 2W-bit product
// using a single W-bit add per cycle.
module vedic_pp_combiner #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   q0,
    input  logic [W-1:0]   q1,
    input  logic [W-1:0]   q2,
    input  logic [W-1:0]   q3,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);
    localparam int H = W / 2;

    typedef enum logic [2:0] {IDLE, MID, LOW, HIGH, DONE} state_t;

    state_t       state, nxt;
    logic [W-1:0] p0, p1, p2, p3, m, u;
    logic         mc;
    logic [W:0]   s;

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid ? MID : IDLE;
            MID:     nxt = LOW;
            LOW:     nxt = HIGH;
            HIGH:    nxt = DONE;
            DONE:    nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    // upper half of q0 lines up with the middle sum; its carry folds into u
    always_comb begin
        s = {{(H+1){1'b0}}, p0[W-1:H]} + {1'b0, m};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0      <= '0;
            p1      <= '0;
            p2      <= '0;
            p3      <= '0;
            m       <= '0;
            mc      <= 1'b0;
            u       <= '0;
            product <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                p0 <= q0;
                p1 <= q1;
                p2 <= q2;
                p3 <= q3;
            end
            if (state == MID)
                {mc, m} <= {1'b0, p1} + {1'b0, p2};
            if (state == LOW) begin
                product[H-1:0] <= p0[H-1:0];
                product[W-1:H] <= s[H-1:0];
                u              <= ({{(W-1){1'b0}}, mc} << H) + W'(s[W:H]);
            end
            if (state == HIGH)
                product[2*W-1:W] <= p3 + u;
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_vedic_pp_combiner.sv
// tb_vedic_pp_combiner: directed scenarios for the partial-product combiner.
module tb_vedic_pp_combiner;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  q0 = '0, q1 = '0, q2 = '0, q3 = '0;
    logic          in_ready, out_valid, busy;
    logic [2*W-1:0] product;
    int            n_cmp = 0;
    int            n_bad = 0;

    vedic_pp_combiner #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a0, a1, a2, a3);
        q0 = a0; q1 = a1; q2 = a2; q3 = a3;
    endtask

    task automatic send(input logic [W-1:0] a0, a1, a2, a3, input string nm);
        int k = 0;
        drive(a0, a1, a2, a3);
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin tick; k++; end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s accept: in_ready=%b required 1", nm, in_ready);
        end
        tick;
        in_valid = 1'b0;
    endtask

    task automatic get(input logic [2*W-1:0] exp, input string nm);
        int k = 0;
        while (!out_valid && k < 20) begin tick; k++; end
        n_cmp++;
        if (out_valid !== 1'b1 || product !== exp) begin
            n_bad++;
            $display("FAIL %s product: got %h valid=%b required %h valid=1", nm, product, out_valid, exp);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s release: out_valid=%b required 0", nm, out_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
            n_bad++;
            $display("FAIL reset: ready/valid/busy=%b product=%h required 100 / 0",
                     {in_ready, out_valid, busy}, product);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [3:0] seen;
        out_ready = 1'b1;
        send(16'h1860, 16'h0870, 16'h1178, 16'h060C, "basic");
        seen[0] = out_valid;
        tick; seen[1] = out_valid;
        tick; seen[2] = out_valid;
        tick; seen[3] = out_valid;
        n_cmp++;
        if (seen !== 4'b1000) begin
            n_bad++;
            $display("FAIL latency: out_valid after edges N..N+3 = %b required 1000 (msb last)", seen);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_done: busy=%b required 1", busy);
        end
        get(32'h06260060, "basic");
        out_ready = 1'b0;
    endtask

    task automatic test_carry;
        send(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, "carry");
        get(32'hFFFE0001, "carry");
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, "wrap");
        get(32'h01FFFDFF, "wrap");
    endtask

    task automatic test_backpressure;
        int k = 0;
        out_ready = 1'b0;
        send(16'h0001, 16'h0001, 16'h0001, 16'h0001, "bp");
        while (!out_valid && k < 20) begin tick; k++; end
        for (int i = 0; i < 10; i++) begin
            drive(16'(i * 16'h1111), 16'hABCD, 16'(16'h0F0F ^ i), 16'h7777);
            in_valid = i[0];
            tick;
            n_cmp++;
            if (product !== 32'h00010201 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: product=%h valid=%b ready=%b required 00010201 1 0",
                         i, product, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        k = 0;
        for (int i = 0; i < 6; i++) begin tick; k += int'(out_valid); end
        n_cmp++;
        if (k != 0) begin
            n_bad++;
            $display("FAIL bp_single: extra out_valid cycles=%0d required 0", k);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]   sets [3][4];
        logic [2*W-1:0] exp [3];
        int acc = 0, got = 0, last = -1;
        logic take;
        sets[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001}; exp[0] = 32'h00010000;
        sets[1] = '{16'h0000, 16'h0000, 16'hFE01, 16'h0000}; exp[1] = 32'h00FE0100;
        sets[2] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001}; exp[2] = 32'h00010201;
        out_ready = 1'b1;
        drive(sets[0][0], sets[0][1], sets[0][2], sets[0][3]);
        in_valid = 1'b1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            take = in_ready && in_valid;
            if (out_valid) begin
                n_cmp++;
                if (product !== exp[got]) begin
                    n_bad++;
                    $display("FAIL b2b product %0d: got %h required %h", got, product, exp[got]);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 5) begin
                        n_bad++;
                        $display("FAIL b2b spacing %0d: got %0d cycles required 5", got, c - last);
                    end
                end
                last = c;
                got++;
            end
            tick;
            if (take) begin
                acc++;
                if (acc < 3) drive(sets[acc][0], sets[acc][1], sets[acc][2], sets[acc][3]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (got != 3) begin
            n_bad++;
            $display("FAIL b2b count: got %0d products required 3", got);
        end
    endtask

    task automatic test_reset_mid;
        int k = 0;
        send(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, "rst_mid");
        tick;
        rst_n = 1'b0;
        tick;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: ready=%b valid=%b product=%h required 1 0 0", in_ready, out_valid, product);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin tick; k += int'(out_valid); end
        out_ready = 1'b0;
        n_cmp++;
        if (k != 0) begin
            n_bad++;
            $display("FAIL rst_mid stale: out_valid cycles=%0d required 0", k);
        end
    endtask

    task automatic test_random;
        logic [W-1:0]   a0, a1, a2, a3;
        logic [2*W-1:0] exp;
        for (int i = 0; i < 1000; i++) begin
            a0 = W'($urandom); a1 = W'($urandom); a2 = W'($urandom); a3 = W'($urandom);
            exp = 32'(a0) + (32'(a1) << 8) + (32'(a2) << 8) + (32'(a3) << 16);
            send(a0, a1, a2, a3, "rand");
            repeat ($urandom_range(0, 6)) tick;
            get(exp, "rand");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
